maxnet_controller: RTL and testbench

//  Sequences the 4-neuron MaxNet winner-take-all competition. Captures four signed
//  Q16.16 scores, applies ReLU, then iterates x_i <= relu(x_i - EPS*sum(x_j, j!=i))

---
 rtl/maxnet_controller.sv | 132 +++++++++++++
 tb/tb_maxnet_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
// 4-neuron MaxNet winner-take-all sequencer.
// Captures four signed Q16.16 scores, rectifies them, then applies one lateral
// inhibition step per cycle until a single neuron remains positive, all neurons
// are zero, or the iteration limit is reached.
//
// Result handshake: out_valid rises when a result is ready and stays high, with
// winner_idx/winner_val/iter_count/status frozen, until the cycle in which
// out_valid & out_ready are both high; that cycle transfers the result and the
// block returns to IDLE. The result outputs keep their values in IDLE.
module maxnet_controller #(
  parameter int          FRAC     = 16,
  parameter logic [15:0] EPS      = 16'h2000,
  parameter int          MAX_ITER = 64,
  parameter int          ITER_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [31:0]  x1,
  input  logic signed [31:0]  x2,
  input  logic signed [31:0]  x3,
  input  logic signed [31:0]  x4,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          winner_idx,
  output logic [31:0]         winner_val,
  output logic [ITER_W-1:0]   iter_count,
  output logic [1:0]          status
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ST_WIN     = 2'b00;
  localparam logic [1:0] ST_NONE    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  state_t            state;
  logic [3:0][31:0]  r;        // rectified neuron values, always >= 0
  logic [3:0][31:0]  r_next;   // values after one inhibition step
  logic [33:0]       sum;
  logic [33:0]       other [4];
  logic [49:0]       prod  [4];
  logic [33:0]       p     [4];
  logic [2:0]        n_pos;
  logic [1:0]        pos_idx;

  // Inhibition step and positive-neuron census on the current registers.
  always_comb begin
    sum     = '0;
    n_pos   = '0;
    pos_idx = '0;
    for (int i = 0; i < 4; i++) begin
      sum = sum + {2'b00, r[i]};
      if (r[i] != '0) begin
        n_pos   = n_pos + 3'd1;
        pos_idx = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      other[i]  = sum - {2'b00, r[i]};
      prod[i]   = {16'b0, other[i]} * {34'b0, EPS};
      p[i]      = prod[i][FRAC +: 34];
      r_next[i] = (p[i] >= {2'b00, r[i]}) ? 32'd0 : (r[i] - p[i][31:0]);
    end
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      r          <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      winner_idx <= '0;
      winner_val <= '0;
      iter_count <= '0;
      status     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            r[0]       <= x1[31] ? 32'd0 : x1;
            r[1]       <= x2[31] ? 32'd0 : x2;
            r[2]       <= x3[31] ? 32'd0 : x3;
            r[3]       <= x4[31] ? 32'd0 : x4;
            iter_count <= '0;
            busy       <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (n_pos == 3'd1) begin
            status     <= ST_WIN;
            winner_idx <= pos_idx;
            winner_val <= r[pos_idx];
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else if (n_pos == 3'd0) begin
            status     <= ST_NONE;
            winner_idx <= '0;
            winner_val <= '0;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else if (iter_count == ITER_W'(MAX_ITER)) begin
            status     <= ST_TIMEOUT;
            winner_idx <= '0;
            winner_val <= '0;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else begin
            r          <= r_next;
            iter_count <= iter_count + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// Bench for maxnet_controller: directed vector table, hand-written reset and
// back-pressure sequences, and randomized scores checked against a model.
module tb_maxnet_controller;

  localparam logic [1:0] ST_WIN     = 2'b00;
  localparam logic [1:0] ST_NONE    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [3:0][31:0]   x_v;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         winner_idx;
  logic [31:0]        winner_val;
  logic [7:0]         iter_count;
  logic [1:0]         status;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0][31:0] x;
    logic [1:0]       st;
    logic [1:0]       idx;
    logic [31:0]      val;
    int               it;
  } vec_t;

  vec_t vecs [7];

  maxnet_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x1         (x_v[0]),
    .x2         (x_v[1]),
    .x3         (x_v[2]),
    .x4         (x_v[3]),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .winner_idx (winner_idx),
    .winner_val (winner_val),
    .iter_count (iter_count),
    .status     (status)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d,
                              input logic [1:0] st, input logic [1:0] idx,
                              input logic [31:0] val, input int it);
    vec_t v;
    v.x   = {d, c, b, a};
    v.st  = st;
    v.idx = idx;
    v.val = val;
    v.it  = it;
    return v;
  endfunction

  // Reference: the MaxNet rules evaluated with plain integer arithmetic.
  function automatic vec_t model(input logic [3:0][31:0] xv);
    vec_t   v;
    longint r [4];
    longint nr [4];
    longint s;
    longint p;
    int     npos;
    int     last;
    v.x = xv; v.st = ST_NONE; v.idx = 0; v.val = 0; v.it = 0;
    for (int i = 0; i < 4; i++)
      r[i] = ($signed(xv[i]) < 0) ? 0 : longint'(xv[i]);
    for (int step = 0; step <= 64; step++) begin
      npos = 0; last = 0; s = 0;
      for (int i = 0; i < 4; i++) begin
        s += r[i];
        if (r[i] > 0) begin npos++; last = i; end
      end
      v.it = step;
      if (npos == 1) begin
        v.st = ST_WIN; v.idx = 2'(last); v.val = 32'(r[last]);
        return v;
      end
      if (npos == 0) begin
        v.st = ST_NONE;
        return v;
      end
      if (step == 64) begin
        v.st = ST_TIMEOUT;
        return v;
      end
      for (int i = 0; i < 4; i++) begin
        p = ((s - r[i]) * 8192) / 65536;
        nr[i] = (p >= r[i]) ? 0 : r[i] - p;
      end
      for (int i = 0; i < 4; i++) r[i] = nr[i];
    end
    return v;
  endfunction

  // Driver: one full transaction, with `hold` cycles of back-pressure.
  task automatic run_and_check(input string name, input vec_t v, input int hold);
    int cyc;
    @(negedge clk);
    x_v   = v.x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, " busy_run"}, 64'(busy), 64'd1);
    check({name, " valid_early"}, 64'(out_valid), 64'd0);
    cyc = 1;
    while (!out_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'(v.it + 2));
    check({name, " status"}, 64'(status), 64'(v.st));
    check({name, " idx"}, 64'(winner_idx), 64'(v.idx));
    check({name, " val"}, 64'(winner_val), 64'(v.val));
    check({name, " iter"}, 64'(iter_count), 64'(v.it));
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      x_v   = 128'(~v.x);
      @(negedge clk);
      check({name, " hold_valid"}, 64'(out_valid), 64'd1);
      check({name, " hold_busy"}, 64'(busy), 64'd1);
      check({name, " hold_val"}, 64'({status, winner_idx, winner_val, iter_count}),
            64'({v.st, v.idx, v.val, 8'(v.it)}));
    end
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    check({name, " valid_drop"}, 64'(out_valid), 64'd0);
    check({name, " busy_drop"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({name, " idle_busy"}, 64'(busy), 64'd0);
    check({name, " idle_hold"}, 64'({status, winner_idx, winner_val, iter_count}),
          64'({v.st, v.idx, v.val, 8'(v.it)}));
  endtask

  task automatic check_zero(input string name);
    check({name, " busy"}, 64'(busy), 64'd0);
    check({name, " valid"}, 64'(out_valid), 64'd0);
    check({name, " idx"}, 64'(winner_idx), 64'd0);
    check({name, " val"}, 64'(winner_val), 64'd0);
    check({name, " iter"}, 64'(iter_count), 64'd0);
    check({name, " status"}, 64'(status), 64'd0);
  endtask

  initial begin
    vec_t v;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    x_v       = '0;

    vecs[0] = mk(32'h40000, 32'h10000, 0, 0, ST_WIN, 2'd0, 32'h3CF80, 3);
    vecs[1] = mk(32'hFFFD0000, 32'h50000, 0, 0, ST_WIN, 2'd1, 32'h50000, 0);
    vecs[2] = mk(0, 32'hFFFF0000, 0, 0, ST_NONE, 2'd0, 0, 0);
    vecs[3] = mk(32'h20000, 32'h20000, 0, 0, ST_TIMEOUT, 2'd0, 0, 64);
    vecs[4] = mk(0, 0, 0, 32'h7FFFFFFF, ST_WIN, 2'd3, 32'h7FFFFFFF, 0);
    vecs[5] = mk(32'h80000000, 32'hFFFFFFFF, 32'hFFFF0000, 32'h80000001, ST_NONE, 2'd0, 0, 0);
    vecs[6] = mk(32'h10000, 32'h10000, 32'h10000, 32'h10000, ST_TIMEOUT, 2'd0, 0, 64);

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // directed table
    for (int i = 0; i < 7; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i], 0);

    // back-pressure with start pulses ignored while busy
    run_and_check("bp", vecs[0], 5);

    // reset in the middle of a run, then a clean transaction
    @(negedge clk);
    x_v   = vecs[0].x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid iter", 64'(iter_count), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("mid_reset_idle");
    run_and_check("after_reset", vecs[1], 0);

    // randomized scores against the model
    for (int n = 0; n < 16; n++) begin
      logic [3:0][31:0] xr;
      for (int i = 0; i < 4; i++)
        xr[i] = 32'(int'($urandom_range(0, 6 * 65536)) - 65536);
      if ($urandom_range(0, 3) == 0) xr[1] = xr[0];
      v = model(xr);
      run_and_check($sformatf("rnd%0d", n), v, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
